// File: rtl/ipu_frame_sched_if.sv
// Handshake/bus bundle for ipu_frame_sched: pixel stream, detector result,
// pipeline gating and averaged-centroid publish channel.
interface ipu_frame_sched_if;
    logic        iEnable;
    logic        iDVAL;
    logic [10:0] iX_Cont;
    logic [10:0] iY_Cont;
    logic        iDet_DVAL;
    logic [10:0] iDet_X;
    logic [10:0] iDet_Y;
    logic        oProc_EN;
    logic        oProc_CLR;
    logic [10:0] oX;
    logic [10:0] oY;
    logic        oValid;
    logic        iReady;
    logic        oLost;
    logic [15:0] oFrame_Cnt;

    modport master (
        output iEnable, iDVAL, iX_Cont, iY_Cont, iDet_DVAL, iDet_X, iDet_Y, iReady,
        input  oProc_EN, oProc_CLR, oX, oY, oValid, oLost, oFrame_Cnt
    );

    modport slave (
        input  iEnable, iDVAL, iX_Cont, iY_Cont, iDet_DVAL, iDet_X, iDet_Y, iReady,
        output oProc_EN, oProc_CLR, oX, oY, oValid, oLost, oFrame_Cnt
    );
endinterface

// File: rtl/ipu_frame_sched.sv
// Frame scheduler: gates the pixel pipeline per frame, averages one centroid per frame
// over 2**AVG_LOG2 frames and publishes it. Define IPU_ROI_EN to restrict to an ROI.
module ipu_frame_sched #(
    parameter int FRAME_W     = 640,
    parameter int FRAME_H     = 480,
    parameter int AVG_LOG2    = 2,
    parameter int DET_TIMEOUT = 64,
    parameter int MISS_LIMIT  = 8
`ifdef IPU_ROI_EN
    ,
    parameter int ROI_X0      = 0,
    parameter int ROI_X1      = 639,
    parameter int ROI_Y0      = 0,
    parameter int ROI_Y1      = 479
`endif
) (
    input logic               iCLK,
    input logic               iRST,
    ipu_frame_sched_if.slave  bus
);
    localparam int SW = 11 + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam int MW = $clog2(MISS_LIMIT + 1);
    localparam int TW = $clog2(DET_TIMEOUT + 1);
    localparam logic [NW-1:0] N_FULL   = NW'(1 << AVG_LOG2);
    localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);
    localparam logic [TW-1:0] TMO      = TW'(DET_TIMEOUT);
    localparam logic [10:0]   X_LAST   = 11'(FRAME_W - 1);
    localparam logic [10:0]   Y_LAST   = 11'(FRAME_H - 1);

    typedef enum logic [2:0] {IDLE, ARM, RUN, COLLECT, UPDATE, PUBLISH} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [NW-1:0]   n_q, n_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            det_vld_q, det_vld_d;
    logic [10:0]     det_x_q, det_x_d, det_y_q, det_y_d;
    logic [10:0]     x_q, x_d, y_q, y_d;
    logic            valid_q, valid_d;
    logic            lost_q, lost_d;
    logic [15:0]     fcnt_q, fcnt_d;
    logic            proc_en, proc_clr;

    logic            sof, eof, pix_roi, det_roi;
    logic [SW-1:0]   sx_nx, sy_nx;
    logic [NW-1:0]   n_nx;
    logic [MW-1:0]   miss_nx;

    assign sof = bus.iDVAL && (bus.iX_Cont == 11'd0) && (bus.iY_Cont == 11'd0);
    assign eof = bus.iDVAL && (bus.iX_Cont == X_LAST) && (bus.iY_Cont == Y_LAST);

`ifdef IPU_ROI_EN
    assign pix_roi = (int'(bus.iX_Cont) >= ROI_X0) && (int'(bus.iX_Cont) <= ROI_X1) &&
                     (int'(bus.iY_Cont) >= ROI_Y0) && (int'(bus.iY_Cont) <= ROI_Y1);
    assign det_roi = (int'(det_x_q) >= ROI_X0) && (int'(det_x_q) <= ROI_X1) &&
                     (int'(det_y_q) >= ROI_Y0) && (int'(det_y_q) <= ROI_Y1);
`else
    assign pix_roi = 1'b1;
    assign det_roi = 1'b1;
`endif

    assign sx_nx   = sum_x_q + {{AVG_LOG2{1'b0}}, det_x_q};
    assign sy_nx   = sum_y_q + {{AVG_LOG2{1'b0}}, det_y_q};
    assign n_nx    = n_q + NW'(1);
    assign miss_nx = (miss_q == MISS_MAX) ? miss_q : miss_q + MW'(1);

    always_comb begin
        state_d   = state_q;
        sum_x_d   = sum_x_q;
        sum_y_d   = sum_y_q;
        n_d       = n_q;
        miss_d    = miss_q;
        tmo_d     = tmo_q;
        det_vld_d = det_vld_q;
        det_x_d   = det_x_q;
        det_y_d   = det_y_q;
        x_d       = x_q;
        y_d       = y_q;
        valid_d   = valid_q;
        lost_d    = lost_q;
        fcnt_d    = fcnt_q;
        proc_en   = 1'b0;
        proc_clr  = 1'b0;

        // Only the first detection of a frame is kept, including one in the EOF cycle.
        if ((state_q == RUN || state_q == COLLECT) && bus.iDet_DVAL && !det_vld_q) begin
            det_vld_d = 1'b1;
            det_x_d   = bus.iDet_X;
            det_y_d   = bus.iDet_Y;
        end

        case (state_q)
            IDLE: state_d = ARM;
            ARM: begin
                if (sof) begin
                    proc_clr  = 1'b1;
                    fcnt_d    = fcnt_q + 16'd1;
                    det_vld_d = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                proc_en = bus.iDVAL && pix_roi;
                if (eof) begin
                    tmo_d   = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (det_vld_q || tmo_q == TMO) state_d = UPDATE;
                else                           tmo_d   = tmo_q + TW'(1);
            end
            UPDATE: begin
                state_d = ARM;
                if (det_vld_q && det_roi) begin
                    miss_d = '0;
                    lost_d = 1'b0;
                    if (n_nx == N_FULL) begin
                        x_d     = sx_nx[SW-1:AVG_LOG2];
                        y_d     = sy_nx[SW-1:AVG_LOG2];
                        valid_d = 1'b1;
                        sum_x_d = '0;
                        sum_y_d = '0;
                        n_d     = '0;
                        state_d = PUBLISH;
                    end else begin
                        sum_x_d = sx_nx;
                        sum_y_d = sy_nx;
                        n_d     = n_nx;
                    end
                end else begin
                    miss_d = miss_nx;
                    if (miss_nx == MISS_MAX) begin
                        lost_d  = 1'b1;
                        sum_x_d = '0;
                        sum_y_d = '0;
                        n_d     = '0;
                    end
                end
            end
            PUBLISH: begin
                // Frames starting while the result waits are skipped but still counted.
                if (sof) fcnt_d = fcnt_q + 16'd1;
                if (valid_q && bus.iReady) begin
                    valid_d = 1'b0;
                    state_d = ARM;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!bus.iEnable) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            lost_d   = 1'b0;
            sum_x_d  = '0;
            sum_y_d  = '0;
            n_d      = '0;
            miss_d   = '0;
            fcnt_d   = fcnt_q;
            proc_en  = 1'b0;
            proc_clr = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= IDLE;
            sum_x_q   <= '0;
            sum_y_q   <= '0;
            n_q       <= '0;
            miss_q    <= '0;
            tmo_q     <= '0;
            det_vld_q <= 1'b0;
            det_x_q   <= '0;
            det_y_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            lost_q    <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            sum_x_q   <= sum_x_d;
            sum_y_q   <= sum_y_d;
            n_q       <= n_d;
            miss_q    <= miss_d;
            tmo_q     <= tmo_d;
            det_vld_q <= det_vld_d;
            det_x_q   <= det_x_d;
            det_y_q   <= det_y_d;
            x_q       <= x_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            lost_q    <= lost_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign bus.oProc_EN   = proc_en;
    assign bus.oProc_CLR  = proc_clr;
    assign bus.oX         = x_q;
    assign bus.oY         = y_q;
    assign bus.oValid     = valid_q;
    assign bus.oLost      = lost_q;
    assign bus.oFrame_Cnt = fcnt_q;
endmodule

// File: tb/tb_ipu_frame_sched.sv
// Scoreboard bench for ipu_frame_sched on a small 8x4 frame; published results are
// checked by a monitor against a queue of hand-computed averages.
module tb_ipu_frame_sched;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int TMO   = 16;
    localparam int BLANK = TMO + 8;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
    } xy_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ipu_frame_sched_if bus();

    ipu_frame_sched #(
        .FRAME_W(W), .FRAME_H(H), .AVG_LOG2(2), .DET_TIMEOUT(TMO), .MISS_LIMIT(8)
`ifdef IPU_ROI_EN
        , .ROI_X0(2), .ROI_X1(5), .ROI_Y0(1), .ROI_Y1(2)
`endif
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus(bus)
    );

    int  total = 0;
    int  bad = 0;
    int  en_cnt = 0;
    int  clr_cnt = 0;
    int  roi_bad = 0;
    xy_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.oValid && bus.iReady) begin
            if (exp_q.size() == 0) chk("unexpected_publish", 1, 0);
            else begin
                xy_t e;
                e = exp_q.pop_front();
                chk("pub_x", int'(bus.oX), int'(e.x));
                chk("pub_y", int'(bus.oY), int'(e.y));
            end
        end
        if (bus.oProc_EN) begin
            en_cnt++;
            if (bus.iX_Cont < 11'd2 || bus.iX_Cont > 11'd5 || bus.iY_Cont < 11'd1 || bus.iY_Cont > 11'd2)
                roi_bad++;
        end
        if (bus.oProc_CLR) clr_cnt++;
    end

    // One full frame followed by blanking; optional detection on the last line,
    // optionally followed by a second, bogus detection (600,400) in the same frame.
    task automatic frame(input bit det, input logic [10:0] dx, input logic [10:0] dy, input bit dup);
        tick();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                bus.iDVAL     = 1'b1;
                bus.iX_Cont   = 11'(x);
                bus.iY_Cont   = 11'(y);
                bus.iDet_DVAL = det && (y == H - 1) && (x == 2 || (dup && x == 5));
                bus.iDet_X    = (x == 2) ? dx : 11'd600;
                bus.iDet_Y    = (x == 2) ? dy : 11'd400;
                tick();
            end
        end
        bus.iDVAL     = 1'b0;
        bus.iDet_DVAL = 1'b0;
        bus.iX_Cont   = '0;
        bus.iY_Cont   = '0;
        repeat (BLANK) tick();
    endtask

    task automatic push(input logic [10:0] x, input logic [10:0] y);
        xy_t e;
        e.x = x;
        e.y = y;
        exp_q.push_back(e);
    endtask

    initial begin
        int en0, clr0;
        rst           = 1'b1;
        bus.iEnable   = 1'b1;
        bus.iReady    = 1'b0;
        bus.iDVAL     = 1'b0;
        bus.iX_Cont   = '0;
        bus.iY_Cont   = '0;
        bus.iDet_DVAL = 1'b0;
        bus.iDet_X    = '0;
        bus.iDet_Y    = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("rst_proc_en", int'(bus.oProc_EN), 0);
        chk("rst_valid", int'(bus.oValid), 0);
        chk("rst_fcnt", int'(bus.oFrame_Cnt), 0);
        chk("rst_lost", int'(bus.oLost), 0);

`ifndef IPU_ROI_EN
        // Four hits average to (103,53) and wait for the consumer.
        en0 = en_cnt; clr0 = clr_cnt;
        frame(1, 11'd100, 11'd50, 0);
        frame(1, 11'd102, 11'd52, 0);
        frame(1, 11'd104, 11'd54, 0);
        frame(1, 11'd106, 11'd56, 0);
        @(negedge clk);
        chk("run_proc_en_seen", int'(en_cnt - en0 > 0), 1);
        chk("run_clr_pulses", clr_cnt - clr0, 4);
        chk("fcnt_4", int'(bus.oFrame_Cnt), 4);
        chk("pub_valid", int'(bus.oValid), 1);
        chk("pub_x_held", int'(bus.oX), 103);
        chk("pub_y_held", int'(bus.oY), 53);
        push(11'd103, 11'd53);

        // Two frames start while publishing: skipped but counted.
        en0 = en_cnt; clr0 = clr_cnt;
        frame(0, '0, '0, 0);
        frame(0, '0, '0, 0);
        @(negedge clk);
        chk("skip_proc_en", en_cnt - en0, 0);
        chk("skip_clr", clr_cnt - clr0, 0);
        chk("fcnt_6", int'(bus.oFrame_Cnt), 6);
        chk("skip_valid", int'(bus.oValid), 1);
        chk("skip_x", int'(bus.oX), 103);
        chk("skip_y", int'(bus.oY), 53);

        tick();
        bus.iReady = 1'b1;
        tick();
        bus.iReady = 1'b0;
        @(negedge clk);
        chk("valid_drop", int'(bus.oValid), 0);
        chk("queue_after_accept", exp_q.size(), 0);

        // Eight misses raise oLost only on the eighth.
        repeat (7) frame(0, '0, '0, 0);
        @(negedge clk);
        chk("lost_after_7", int'(bus.oLost), 0);
        frame(0, '0, '0, 0);
        @(negedge clk);
        chk("lost_after_8", int'(bus.oLost), 1);
        chk("fcnt_14", int'(bus.oFrame_Cnt), 14);

        // A hit clears oLost; the duplicate detection must be ignored; Y truncates.
        frame(1, 11'd10, 11'd10, 1);
        @(negedge clk);
        chk("lost_cleared", int'(bus.oLost), 0);
        tick();
        bus.iReady = 1'b1;
        frame(1, 11'd20, 11'd12, 0);
        frame(1, 11'd30, 11'd14, 0);
        push(11'd25, 11'd13);
        frame(1, 11'd40, 11'd17, 0);
        @(negedge clk);
        chk("queue_after_avg2", exp_q.size(), 0);
        chk("valid_low_avg2", int'(bus.oValid), 0);
        chk("fcnt_18", int'(bus.oFrame_Cnt), 18);

        // Disable clears the partial average and gates oProc_EN at once.
        bus.iReady = 1'b0;
        frame(1, 11'd200, 11'd200, 0);
        tick();
        bus.iDVAL = 1'b1; bus.iX_Cont = 11'd0; bus.iY_Cont = 11'd0;
        tick();
        bus.iX_Cont = 11'd1;
        @(negedge clk);
        chk("run_proc_en", int'(bus.oProc_EN), 1);
        tick();
        bus.iX_Cont = 11'd2;
        bus.iEnable = 1'b0;
        @(negedge clk);
        chk("dis_proc_en", int'(bus.oProc_EN), 0);
        tick();
        bus.iDVAL = 1'b0;
        en0 = en_cnt; clr0 = clr_cnt;
        frame(1, 11'd1, 11'd1, 0);
        @(negedge clk);
        chk("dis_fcnt_held", int'(bus.oFrame_Cnt), 20);
        chk("dis_proc_en_cnt", en_cnt - en0, 0);
        chk("dis_clr_cnt", clr_cnt - clr0, 0);
        tick();
        bus.iEnable = 1'b1;
        bus.iReady  = 1'b1;
        repeat (3) tick();
        frame(1, 11'd8, 11'd4, 0);
        frame(1, 11'd8, 11'd4, 0);
        frame(1, 11'd8, 11'd4, 0);
        push(11'd9, 11'd5);
        frame(1, 11'd12, 11'd8, 0);
        @(negedge clk);
        chk("queue_after_avg3", exp_q.size(), 0);
        chk("fcnt_24", int'(bus.oFrame_Cnt), 24);
`else
        // ROI 2..5 x 1..2: 8 pixels enabled; detection (50,50) is a miss.
        en0 = en_cnt;
        frame(1, 11'd50, 11'd50, 0);
        @(negedge clk);
        chk("roi_proc_en_cnt", en_cnt - en0, 8);
        chk("roi_outside_en", roi_bad, 0);
        repeat (6) frame(1, 11'd50, 11'd50, 0);
        @(negedge clk);
        chk("roi_lost_7", int'(bus.oLost), 0);
        frame(1, 11'd50, 11'd50, 0);
        @(negedge clk);
        chk("roi_lost_8", int'(bus.oLost), 1);
        frame(1, 11'd3, 11'd2, 0);
        @(negedge clk);
        chk("roi_hit_clears", int'(bus.oLost), 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
